adc_axis_frame_packer: RTL and testbench

Downstream stage of the AD9244 ADC AXI-Stream master: consumes one ADC sample per input beat, converts the 14-bit offset-binary code to 16-bit two's complement, and packs two samples per 32-bit output word. Output is an AXI-Stream master with `tlast` marking fixed-length frames, feeding the DMA/OFDM receive path. Also counts out-of-range (clipped) samples and emitted frames.

---
 rtl/adc_pkt_pkg.sv | 21 ++
 rtl/axis_out_slice.sv | 32 +++
 rtl/adc_axis_frame_packer.sv | 125 ++++++++++++
 tb/tb_adc_axis_frame_packer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkt_pkg.sv
// Shared types and helpers for the ADC AXI-Stream frame packer.
// Offset-binary to two's-complement conversion lives here.
package adc_pkt_pkg;

  localparam int ADC_OTR_BIT = 14;
  localparam int ADC_DATA_W  = 14;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Flip the MSB to move mid-scale to zero, then sign-extend to 16 bits.
  function automatic logic [15:0] ob14_to_s16(
    input logic [ADC_DATA_W-1:0] d
  );
    return {{2{~d[13]}}, ~d[13], d[12:0]};
  endfunction

endpackage

// File: rtl/axis_out_slice.sv
// One-entry AXI-Stream output register (data, last, valid).
// The owner must only assert load when the entry is free or draining.
module axis_out_slice #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic              last,
  output logic [DATA_W-1:0] data
);

  // Hold the word until it is taken; a new load may replace a taken word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      last  <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= load_last;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_axis_frame_packer.sv
// Packs two converted ADC samples per 32-bit AXI-Stream word,
// cuts fixed-length frames with tlast and counts clips/frames.
module adc_axis_frame_packer
  import adc_pkt_pkg::*;
#(
  parameter int FRAME_WORDS = 256,
  parameter int CNT_W       = 16
) (
  input  logic             s00_axis_aclk,
  input  logic             s00_axis_areset,
  input  logic             enable,
  input  logic [31:0]      s00_axis_tdata,
  input  logic             s00_axis_tvalid,
  output logic             s00_axis_tready,
  input  logic             s00_axis_tlast,
  output logic [31:0]      m00_axis_tdata,
  output logic             m00_axis_tvalid,
  input  logic             m00_axis_tready,
  output logic             m00_axis_tlast,
  output logic [3:0]       m00_axis_tstrb,
  output logic [CNT_W-1:0] clip_count,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

  state_t      state;
  logic        hi;
  logic [15:0] half;
  logic [15:0] word_cnt;

  logic [15:0] s16;
  logic        otr;
  logic        out_ok;
  logic        at_bound;
  logic        drain_hold;
  logic        accept;
  logic        load;
  logic        last_word;
  logic        unused;

  assign s16       = ob14_to_s16(s00_axis_tdata[ADC_DATA_W-1:0]);
  assign otr       = s00_axis_tdata[ADC_OTR_BIT];
  assign unused    = ^{s00_axis_tdata[31:15], s00_axis_tlast};
  assign out_ok    = !m00_axis_tvalid || m00_axis_tready;
  assign at_bound  = !hi && (word_cnt == 16'd0);
  // In DRAIN a frame boundary means the tlast word is already loaded.
  assign drain_hold = (state == DRAIN) && at_bound;
  assign last_word = (word_cnt == LAST_IDX);

  // Ready: free in IDLE, gated on output space for the completing half.
  always_comb begin
    s00_axis_tready = 1'b0;
    if (!s00_axis_areset) begin
      if (state == IDLE)    s00_axis_tready = 1'b1;
      else if (drain_hold)  s00_axis_tready = 1'b0;
      else if (!hi)         s00_axis_tready = 1'b1;
      else                  s00_axis_tready = out_ok;
    end
  end

  assign accept = (state != IDLE) && s00_axis_tvalid && s00_axis_tready;
  assign load   = accept && hi;

  assign m00_axis_tstrb = 4'b1111;

  // Sequencer: capture state, half register and word index.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state    <= IDLE;
      hi       <= 1'b0;
      half     <= '0;
      word_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          hi       <= 1'b0;
          word_cnt <= '0;
          if (enable) state <= RUN;
        end
        RUN, DRAIN: begin
          if (accept && !hi) begin
            half <= s16;
            hi   <= 1'b1;
          end
          if (load) begin
            hi       <= 1'b0;
            word_cnt <= last_word ? 16'd0 : word_cnt + 16'd1;
          end
          if (state == RUN && !enable) state <= DRAIN;
          if (drain_hold && out_ok)    state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status counters: saturating clips, wrapping frames.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      clip_count  <= '0;
      frame_count <= '0;
    end else begin
      if (accept && otr && clip_count != '1)
        clip_count <= clip_count + 1'b1;
      if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast)
        frame_count <= frame_count + 1'b1;
    end
  end

  axis_out_slice #(
    .DATA_W(32)
  ) u_out (
    .clk       (s00_axis_aclk),
    .rst       (s00_axis_areset),
    .load      (load),
    .load_data ({s16, half}),
    .load_last (last_word),
    .ready     (m00_axis_tready),
    .valid     (m00_axis_tvalid),
    .last      (m00_axis_tlast),
    .data      (m00_axis_tdata)
  );

endmodule

// File: tb/tb_adc_axis_frame_packer.sv
// Directed bench for adc_axis_frame_packer (FRAME_WORDS=4).
// A second instance with CNT_W=4 covers counter saturation/wrap.
module tb_adc_axis_frame_packer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        m_tready;

  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [3:0]  m_tstrb;
  logic [15:0] clip;
  logic [15:0] frames;

  logic        s_tready2;
  logic [31:0] m_tdata2;
  logic        m_tvalid2;
  logic        m_tlast2;
  logic [3:0]  m_tstrb2;
  logic [3:0]  clip2;
  logic [3:0]  frames2;

  int checks = 0;
  int errors = 0;

  logic [32:0] q[$];

  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic        prev_l = 1'b0;
  logic [31:0] prev_d = '0;

  adc_axis_frame_packer #(
    .FRAME_WORDS(4),
    .CNT_W(16)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .enable          (enable),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready),
    .s00_axis_tlast  (s_tlast),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tstrb  (m_tstrb),
    .clip_count      (clip),
    .frame_count     (frames)
  );

  adc_axis_frame_packer #(
    .FRAME_WORDS(4),
    .CNT_W(4)
  ) dut_small (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .enable          (enable),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready2),
    .s00_axis_tlast  (s_tlast),
    .m00_axis_tdata  (m_tdata2),
    .m00_axis_tvalid (m_tvalid2),
    .m00_axis_tready (m_tready),
    .m00_axis_tlast  (m_tlast2),
    .m00_axis_tstrb  (m_tstrb2),
    .clip_count      (clip2),
    .frame_count     (frames2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion: offset binary minus mid-scale.
  function automatic logic [15:0] cv(input int c);
    int v;
    v = c - 8192;
    return 16'(v);
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic send(input int c, input logic otr);
    int n;
    n = 0;
    @(negedge clk);
    s_tdata  = {17'h0, otr, 14'(c)};
    s_tvalid = 1'b1;
    #1;
    while (!s_tready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout code %h", c);
    end else begin
      @(posedge clk);
    end
    #1 s_tvalid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Collect accepted words and check AXIS hold rules while stalled.
  always @(posedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        checks++;
        if (!(m_tvalid && m_tdata == prev_d && m_tlast == prev_l)) begin
          errors++;
          $display("FAIL stall_hold actual v%b %h l%b required v1 %h l%b",
                   m_tvalid, m_tdata, m_tlast, prev_d, prev_l);
        end
      end
      if (m_tvalid && m_tready) q.push_back({m_tlast, m_tdata});
      prev_v = m_tvalid;
      prev_r = m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
    end
  end

  typedef struct {
    int          lo;
    int          hi;
    logic [31:0] word;
    logic        last;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'h0000, 16'h0001, 32'hE001E000, 1'b0};
    tbl[1] = '{16'h0002, 16'h0003, 32'hE003E002, 1'b0};
    tbl[2] = '{16'h0004, 16'h0005, 32'hE005E004, 1'b0};
    tbl[3] = '{16'h0006, 16'h0007, 32'hE007E006, 1'b1};
    tbl[4] = '{16'h0000, 16'h2000, 32'h0000E000, 1'b0};
    tbl[5] = '{16'h3FFF, 16'h1FFF, 32'hFFFF1FFF, 1'b0};
    tbl[6] = '{16'h2001, 16'h1FFF, 32'hFFFF0001, 1'b0};
    tbl[7] = '{16'h3000, 16'h0FFF, 32'hEFFF1000, 1'b1};

    rst      = 1'b1;
    enable   = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_out", {31'h0, m_tvalid, m_tlast, m_tdata}, 64'd0);

    rst = 1'b0;
    #1;
    chk("idle_ready", 64'(s_tready), 64'd1);
    chk("rst_counts", {clip, frames}, 64'd0);
    chk("tstrb", 64'(m_tstrb), 64'hF);

    enable   = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);

    // Table: word value, one-cycle latency and tlast placement.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].lo, 1'b0);
      send(tbl[i].hi, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {30'h0, m_tvalid, m_tlast, m_tdata},
          {30'h0, 1'b1, tbl[i].last, tbl[i].word});
      if (i == 3) begin
        @(negedge clk);
        chk("frame_after_8", 64'(frames), 64'd1);
      end
    end
    repeat (2) @(negedge clk);
    chk("frame_after_tbl", 64'(frames), 64'd2);

    // Downstream stall of 50 cycles in the middle of a stream.
    q.delete();
    fork
      begin
        for (int i = 0; i < 16; i++) send(100 + i, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        m_tready = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        chk("stall_ready", {m_tvalid, s_tready}, 64'b10);
        repeat (40) @(negedge clk);
        m_tready = 1'b1;
      end
    join
    wait_q(8);
    chk("stall_count", 64'(q.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < q.size())
        chk($sformatf("stall_w%0d", k), 64'(q[k]),
            {31'h0, (k % 4 == 3),
             cv(101 + 2 * k), cv(100 + 2 * k)});
    end

    // Drop enable after word 1: the frame still completes.
    q.delete();
    for (int i = 0; i < 4; i++) send(200 + i, 1'b0);
    enable = 1'b0;
    for (int i = 4; i < 8; i++) send(200 + i, 1'b0);
    repeat (3) @(negedge clk);
    chk("drain_count", 64'(q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < q.size())
        chk($sformatf("drain_w%0d", k), 64'(q[k]),
            {31'h0, (k == 3), cv(201 + 2 * k), cv(200 + 2 * k)});
    end
    chk("drain_idle_ready", 64'(s_tready), 64'd1);
    chk("drain_frames", 64'(frames), 64'd5);
    for (int i = 0; i < 4; i++) send(300 + i, 1'b0);
    repeat (4) @(negedge clk);
    chk("idle_discard", {m_tvalid, 8'(q.size())}, 64'd4);

    // Clip counting and saturation, frame counter wrap.
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 30; i++) send(i + 10, (i % 3 == 2));
    repeat (3) @(negedge clk);
    chk("clip_30", {clip, 12'h0, clip2}, {16'd10, 12'h0, 4'd10});
    for (int i = 0; i < 20; i++) send(16'h3FFF, 1'b1);
    repeat (3) @(negedge clk);
    chk("clip_sat", {clip, 12'h0, clip2}, {16'd30, 12'h0, 4'd15});
    chk("frames_11", {frames, 12'h0, frames2}, {16'd11, 12'h0, 4'd11});
    for (int i = 0; i < 38; i++) send(i, 1'b0);
    repeat (3) @(negedge clk);
    chk("frame_wrap", {frames, 12'h0, frames2}, {16'd16, 12'h0, 4'd0});

    // Asynchronous reset with a held word and a pending half.
    m_tready = 1'b0;
    send(16'h2000, 1'b0);
    send(16'h2001, 1'b0);
    send(16'h1234, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out",
        {29'h0, m_tvalid, m_tlast, s_tready, m_tdata}, 64'd0);
    chk("async_rst_counts", {clip, frames}, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    m_tready = 1'b1;
    q.delete();
    @(negedge clk);
    send(16'h0000, 1'b0);
    send(16'h3FFF, 1'b0);
    wait_q(1);
    chk("post_rst_count", 64'(q.size()), 64'd1);
    if (q.size() > 0)
      chk("post_rst_word", 64'(q[0]), {31'h0, 1'b0, 32'h1FFFE000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
